// File: rtl/rip_bram_port_arbiter_pkg.sv
// ============================================================================
// rip_bram_arb_pkg: shared types and helpers for the BRAM port-1 arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package rip_bram_arb_pkg;

  typedef enum logic [0:0] {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  // Index width that stays legal (>=1) even for a single requester
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rip_bram_port_arbiter_if.sv
// ============================================================================
// rip_bram_port_arbiter_if: requester-side valid/ready request and response bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface rip_bram_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_lock, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_lock, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

`default_nettype wire

// File: rtl/rip_bram_port_arbiter_rr.sv
// ============================================================================
// rip_rr_arbiter: combinational round-robin pick starting at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rip_rr_arbiter
  import rip_bram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  wire logic [N-1:0]            req,
  input  wire logic [idx_width(N)-1:0] ptr,
  output logic      [N-1:0]            grant,
  output logic      [idx_width(N)-1:0] grant_idx
);

  localparam int c_IDW = idx_width(N);

  always_comb begin
    int   w_idx;
    logic w_found;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        grant_idx      = c_IDW'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rip_bram_port_arbiter.sv
// ============================================================================
// rip_bram_port_arbiter: round-robin sharing of BRAM port 1 with post-reset clear
// Rev 1.0
// ============================================================================
`default_nettype none

module rip_bram_port_arbiter
  import rip_bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 2,
  parameter int INIT_CLEAR = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rstn,
  rip_bram_port_arbiter_if.slave     req_bus,
  output logic                       init_done,
  output logic                       bram_en,
  output logic                       bram_we,
  output logic      [ADDR_WIDTH-1:0] bram_addr,
  output logic      [DATA_WIDTH-1:0] bram_din,
  input  wire logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int                 c_IDW  = idx_width(NUM_REQ);
  localparam logic [c_IDW-1:0]   c_LAST = c_IDW'(NUM_REQ - 1);

  arb_state_e              r_state;
  arb_state_e              w_state_nx;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic [ADDR_WIDTH-1:0]   w_clr_addr_nx;
  logic [c_IDW-1:0]        r_rr_ptr;
  logic [c_IDW-1:0]        w_rr_ptr_nx;
  logic [NUM_REQ-1:0]      r_rsp_valid;

  logic                    w_run;
  logic [NUM_REQ-1:0]      w_arb_req;
  logic [NUM_REQ-1:0]      w_grant;
  logic [c_IDW-1:0]        w_grant_idx;
  logic                    w_accept;
  logic                    w_sel_we;
  logic                    w_sel_lock;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;

  // Requests are invisible to the arbiter until the clear has finished
  assign w_run     = (r_state == ARB_RUN);
  assign w_arb_req = w_run ? req_bus.req_valid : '0;

  rip_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .req       (w_arb_req),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_accept          = |w_grant;
  assign w_sel_we          = |(req_bus.req_we & w_grant);
  assign w_sel_lock        = |(req_bus.req_lock & w_grant);
  assign req_bus.req_ready = w_grant;
  assign req_bus.rsp_valid = r_rsp_valid;
  assign req_bus.rsp_rdata = bram_dout;

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr  = req_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_rr_ptr_nx = r_rr_ptr;
    if (w_accept) begin
      if (w_sel_lock) begin
        w_rr_ptr_nx = w_grant_idx;
      end else if (w_grant_idx == c_LAST) begin
        w_rr_ptr_nx = '0;
      end else begin
        w_rr_ptr_nx = w_grant_idx + c_IDW'(1);
      end
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_clr_addr_nx = r_clr_addr;
    init_done     = 1'b0;
    bram_en       = 1'b0;
    bram_we       = 1'b0;
    bram_addr     = '0;
    bram_din      = '0;
    case (r_state)
      ARB_INIT: begin
        bram_en       = 1'b1;
        bram_we       = 1'b1;
        bram_addr     = r_clr_addr;
        w_clr_addr_nx = r_clr_addr + ADDR_WIDTH'(1);
        if (r_clr_addr == '1) begin
          w_state_nx = ARB_RUN;
        end
      end
      ARB_RUN: begin
        init_done = 1'b1;
        bram_en   = w_accept;
        bram_we   = w_accept & w_sel_we;
        bram_addr = w_sel_addr;
        bram_din  = w_sel_wdata;
      end
      default: begin
        w_state_nx = ARB_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= (INIT_CLEAR != 0) ? ARB_INIT : ARB_RUN;
      r_clr_addr  <= '0;
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_clr_addr  <= w_clr_addr_nx;
      r_rr_ptr    <= w_rr_ptr_nx;
      r_rsp_valid <= w_grant;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rip_bram_port_arbiter.sv
// ============================================================================
// tb_rip_bram_port_arbiter: directed vector bench with a read-first BRAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rip_bram_port_arbiter;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  lock;
    logic [1:0]  we;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  e_ready;
    logic        e_bwe;
    logic [3:0]  e_baddr;
    logic [1:0]  e_rsp;
    logic [31:0] e_rdata;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic        rstn3;
  logic        init_done, bram_en, bram_we;
  logic [3:0]  bram_addr;
  logic [31:0] bram_din, bram_dout;
  logic        init_done3, bram_en3, bram_we3;
  logic [3:0]  bram_addr3;
  logic [31:0] bram_din3;
  logic [31:0] bram_dout3;
  logic [31:0] mem [0:15];
  vec_t        vecs[$];
  int          pass_cnt;
  int          total_cnt;

  rip_bram_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
  rip_bram_port_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(4), .DATA_WIDTH(32)) bus3 ();

  rip_bram_port_arbiter #(
    .DATA_WIDTH (32), .ADDR_WIDTH (4), .NUM_REQ (2), .INIT_CLEAR (1)
  ) u_dut (
    .clk (clk), .rstn (rstn), .req_bus (bus), .init_done (init_done),
    .bram_en (bram_en), .bram_we (bram_we), .bram_addr (bram_addr),
    .bram_din (bram_din), .bram_dout (bram_dout)
  );

  rip_bram_port_arbiter #(
    .DATA_WIDTH (32), .ADDR_WIDTH (4), .NUM_REQ (3), .INIT_CLEAR (0)
  ) u_dut3 (
    .clk (clk), .rstn (rstn3), .req_bus (bus3), .init_done (init_done3),
    .bram_en (bram_en3), .bram_we (bram_we3), .bram_addr (bram_addr3),
    .bram_din (bram_din3), .bram_dout (bram_dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first registered RAM port, preloaded with all ones
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
    bram_dout = '0;
  end
  always @(posedge clk) begin
    if (bram_en) begin
      bram_dout <= mem[bram_addr];
      if (bram_we) mem[bram_addr] <= bram_din;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] v, input logic [1:0] l, input logic [1:0] w,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [1:0] er, input logic ebwe, input logic [3:0] ea,
                     input logic [1:0] ersp, input logic [31:0] erd);
    vec_t t;
    t.valid = v; t.lock = l; t.we = w; t.a0 = a0; t.a1 = a1; t.wd0 = wd0; t.wd1 = wd1;
    t.e_ready = er; t.e_bwe = ebwe; t.e_baddr = ea; t.e_rsp = ersp; t.e_rdata = erd;
    vecs.push_back(t);
  endtask

  task automatic drive_read0(input logic [1:0] v, input logic [3:0] a0);
    bus.req_valid = v;
    bus.req_lock  = '0;
    bus.req_we    = '0;
    bus.req_addr  = {4'd0, a0};
    bus.req_wdata = '0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rstn  = 1'b0;
    rstn3 = 1'b0;
    bram_dout3 = '0;
    drive_read0(2'b00, 4'd0);
    bus3.req_valid = '0; bus3.req_lock = '0; bus3.req_we = '0;
    bus3.req_addr  = '0; bus3.req_wdata = '0;

    // Test 1 reads, then writes of distinct lines, alternation, write/read, lock
    for (int k = 0; k < 16; k++)
      add(2'b01, 2'b00, 2'b00, 4'(k), 4'd0, 0, 0, 2'b01, 1'b0, 4'(k), (k == 0) ? 2'b00 : 2'b01, 0);
    add(2'b01, 2'b00, 2'b01, 4'd3, 4'd0, 32'h3333_3333, 0, 2'b01, 1'b1, 4'd3, 2'b01, 0);
    add(2'b10, 2'b00, 2'b10, 4'd0, 4'd5, 0, 32'h5555_5555, 2'b10, 1'b1, 4'd5, 2'b01, 0);
    add(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 0, 0, 2'b01, 1'b0, 4'd3, 2'b10, 0);
    add(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 0, 0, 2'b10, 1'b0, 4'd5, 2'b01, 32'h3333_3333);
    add(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 0, 0, 2'b01, 1'b0, 4'd3, 2'b10, 32'h5555_5555);
    add(2'b11, 2'b00, 2'b00, 4'd3, 4'd5, 0, 0, 2'b10, 1'b0, 4'd5, 2'b01, 32'h3333_3333);
    add(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 0, 0, 2'b00, 1'b0, 4'd0, 2'b10, 32'h5555_5555);
    add(2'b01, 2'b00, 2'b01, 4'd7, 4'd0, 32'hDEAD_BEEF, 0, 2'b01, 1'b1, 4'd7, 2'b00, 0);
    add(2'b01, 2'b00, 2'b00, 4'd7, 4'd0, 0, 0, 2'b01, 1'b0, 4'd7, 2'b01, 0);
    add(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 0, 0, 2'b00, 1'b0, 4'd0, 2'b01, 32'hDEAD_BEEF);
    add(2'b10, 2'b00, 2'b00, 4'd0, 4'd5, 0, 0, 2'b10, 1'b0, 4'd5, 2'b00, 0);
    add(2'b11, 2'b01, 2'b00, 4'd3, 4'd5, 0, 0, 2'b01, 1'b0, 4'd3, 2'b10, 32'h5555_5555);
    for (int k = 0; k < 3; k++)
      add(2'b11, 2'b01, 2'b00, 4'd3, 4'd5, 0, 0, 2'b01, 1'b0, 4'd3, 2'b01, 32'h3333_3333);
    add(2'b10, 2'b00, 2'b00, 4'd3, 4'd5, 0, 0, 2'b10, 1'b0, 4'd5, 2'b01, 32'h3333_3333);
    add(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 0, 0, 2'b00, 1'b0, 4'd0, 2'b10, 32'h5555_5555);

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset rsp_valid", 64'(bus.rsp_valid), 0);
    check("reset init_done", 64'(init_done), 0);

    // Clear sequence: valid held high must not be served
    next_cycle();
    rstn = 1'b1;
    drive_read0(2'b11, 4'd9);
    for (int k = 0; k < 16; k++) begin
      if (k != 0) next_cycle();
      @(negedge clk);
      check($sformatf("clear%0d", k),
            64'({bram_en, bram_we, bram_addr, bram_din, bus.req_ready, init_done}),
            64'({1'b1, 1'b1, 4'(k), 32'd0, 2'b00, 1'b0}));
    end
    next_cycle();
    drive_read0(2'b00, 4'd0);
    @(negedge clk);
    check("init_done after clear", 64'({init_done, bus.req_ready}), 64'({1'b1, 2'b00}));

    foreach (vecs[i]) begin
      next_cycle();
      bus.req_valid = vecs[i].valid;
      bus.req_lock  = vecs[i].lock;
      bus.req_we    = vecs[i].we;
      bus.req_addr  = {vecs[i].a1, vecs[i].a0};
      bus.req_wdata = {vecs[i].wd1, vecs[i].wd0};
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 64'(bus.req_ready), 64'(vecs[i].e_ready));
      check($sformatf("vec%0d bram_en/we", i), 64'({bram_en, bram_we}),
            64'({|vecs[i].e_ready, vecs[i].e_bwe}));
      if (vecs[i].e_ready != 2'b00)
        check($sformatf("vec%0d bram_addr", i), 64'(bram_addr), 64'(vecs[i].e_baddr));
      check($sformatf("vec%0d rsp_valid", i), 64'(bus.rsp_valid), 64'(vecs[i].e_rsp));
      if (vecs[i].e_rsp != 2'b00)
        check($sformatf("vec%0d rsp_rdata", i), 64'(bus.rsp_rdata), 64'(vecs[i].e_rdata));
    end

    // Reset during an accepted read drops its response and restarts the clear
    next_cycle();
    drive_read0(2'b01, 4'd3);
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    drive_read0(2'b00, 4'd0);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) next_cycle();
      if (k == 9) rstn = 1'b0;
      @(negedge clk);
      if (k == 0) check("mid-op reset rsp_valid", 64'(bus.rsp_valid), 0);
      check($sformatf("clear1 addr%0d", k), 64'({bram_addr, init_done}), 64'({4'(k), 1'b0}));
    end
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) next_cycle();
      @(negedge clk);
      check($sformatf("clear2 addr%0d", k), 64'({bram_we, bram_addr, init_done}),
            64'({1'b1, 4'(k), 1'b0}));
    end
    next_cycle();
    drive_read0(2'b01, 4'd3);
    @(negedge clk);
    check("init_done after restart", 64'(init_done), 1);
    next_cycle();
    drive_read0(2'b01, 4'd7);
    @(negedge clk);
    check("recleared @3", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({2'b01, 32'd0}));
    next_cycle();
    drive_read0(2'b00, 4'd0);
    @(negedge clk);
    check("recleared @7", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({2'b01, 32'd0}));

    // Three requesters, no clear: immediate grant, pointer wraps to 0
    next_cycle();
    rstn3 = 1'b1;
    bus3.req_valid = 3'b100;
    @(negedge clk);
    check("n3 first grant", 64'({bus3.req_ready, init_done3}), 64'({3'b100, 1'b1}));
    next_cycle();
    bus3.req_valid = 3'b111;
    @(negedge clk);
    check("n3 wrap grant", 64'(bus3.req_ready), 64'(3'b001));
    check("n3 rsp_valid", 64'(bus3.rsp_valid), 64'(3'b100));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
